serial_subtractor: RTL

Bit-serial WIDTH-bit subtractor computing a − b, LSB first, one bit per clock. It sits directly upstream of the team's `fullsubs` cell: it feeds `fullsubs` one operand bit pair plus the registered borrow each cycle, then collects `diff`/`bout`. It is the area-minimal alternative to a ripple array of `fullsubs` and sits behind a simple start/done handshake.

---
 rtl/serial_subtractor_pkg.sv | 5 +
 rtl/serial_subtractor_if.sv | 18 +
 rtl/serial_subtractor_fullsubs.sv | 11 +
 rtl/serial_subtractor.sv | 81 ++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subs_pkg: shared FSM state type and width limit for serial_subtractor
package serial_subs_pkg;
  localparam int SUBS_MAX_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} subs_state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus; ovf exists only with SERIAL_SUBS_OVF_EN
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBS_OVF_EN
  logic             ovf;
  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_fullsubs.sv
// fullsubs: one-bit full subtractor, x - y - bin
module fullsubs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = x ^ y ^ bin;
  assign bout = (~x & (y | bin)) | (y & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock around one fullsubs cell
// Optional signed-overflow flag ovf is built when SERIAL_SUBS_OVF_EN is defined.
module serial_subtractor
  import serial_subs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  if (WIDTH < 1 || WIDTH > SUBS_MAX_WIDTH) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range");
  end
  subs_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             fs_diff, fs_bout;
  logic             accept, shift, last;
  fullsubs u_fs (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .bin (borrow_q),
    .diff(fs_diff),
    .bout(fs_bout)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    accept  = state_q == IDLE && bus.start;
    shift   = state_q == SHIFT;
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q == IDLE  ? (bus.start ? SHIFT : IDLE) :
              state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    bus.busy = state_q != IDLE;
    bus.done = state_q == DONE;
  end
  // result fills from the MSB so bit WIDTH-1 lands last, after WIDTH shifts
  always_comb begin
    a_sr_d   = accept ? bus.a : shift ? a_sr_q >> 1 : a_sr_q;
    b_sr_d   = accept ? bus.b : shift ? b_sr_q >> 1 : b_sr_q;
    res_d    = accept ? '0 : shift ? WIDTH'({fs_diff, res_q} >> 1) : res_q;
    borrow_d = accept ? 1'b0 : shift ? fs_bout : borrow_q;
    cnt_d    = accept ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.diff = res_q;
  assign bus.bout = borrow_q;
`ifdef SERIAL_SUBS_OVF_EN
  logic ovf_q, ovf_d;
  // on the last shift the sr LSBs are the latched operand MSBs
  always_comb
    ovf_d = accept ? 1'b0 :
            shift && last ? (a_sr_q[0] ^ b_sr_q[0]) & (a_sr_q[0] ^ fs_diff) : ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`endif
endmodule
